// File: rtl/wb_timer_if.sv
// Wishbone pipelined bus bundle shared by the timer slave and its bus master.
interface wishbone_if #(
    parameter int unsigned AW = 32
) ();
    logic          cyc;
    logic          stb;
    logic          we;
    logic [AW-1:0] addr;
    logic [3:0]    sel;
    logic [31:0]   wdata;
    logic [31:0]   rdata;
    logic          ack;
    logic          stall;
    logic          err;
    logic          rty;

    modport MASTER (
        output cyc, stb, we, addr, sel, wdata,
        input  rdata, ack, stall, err, rty
    );

    modport SLAVE (
        input  cyc, stb, we, addr, sel, wdata,
        output rdata, ack, stall, err, rty
    );
endinterface

// File: rtl/wb_timer.sv
// Machine timer slave: 64-bit mtime/mtimecmp, prescaled tick, level interrupt,
// single-cycle-latency Wishbone pipelined register access.
module wb_timer #(
    parameter int unsigned AW         = 32,
    parameter int unsigned PRESCALE_W = 16
) (
    input  logic      clk_i,
    input  logic      rstn_i,
    wishbone_if.SLAVE wb_if,
    output logic      timer_irq_o
);

    typedef enum logic [2:0] {
        REG_MTIME_LO = 3'd0,
        REG_MTIME_HI = 3'd1,
        REG_CMP_LO   = 3'd2,
        REG_CMP_HI   = 3'd3,
        REG_CTRL     = 3'd4,
        REG_PRESCALE = 3'd5,
        REG_RSV6     = 3'd6,
        REG_RSV7     = 3'd7
    } reg_sel_e;

    logic [63:0]           mtime_q,    mtime_d;
    logic [63:0]           mtimecmp_q, mtimecmp_d;
    logic                  en_q,       en_d;
    logic [PRESCALE_W-1:0] prescale_q, prescale_d;
    logic [PRESCALE_W-1:0] pcnt_q,     pcnt_d;
    logic                  ack_q,      ack_d;
    logic [31:0]           rdata_q,    rdata_d;
    logic                  irq_q,      irq_d;

    logic                  accept;
    logic                  wr_en;
    logic                  tick;
    reg_sel_e              reg_sel;
    logic [31:0]           rd_mux;
    logic                  unused_addr;

    function automatic logic [31:0] byte_merge(
        input logic [31:0] old_val,
        input logic [31:0] wr_val,
        input logic [3:0]  be
    );
        logic [31:0] res;
        res = old_val;
        for (int unsigned i = 0; i < 4; i++) begin
            if (be[i]) begin
                res[8*i +: 8] = wr_val[8*i +: 8];
            end
        end
        return res;
    endfunction

    assign accept      = wb_if.cyc & wb_if.stb;
    assign wr_en       = accept & wb_if.we;
    assign reg_sel     = reg_sel_e'(wb_if.addr[4:2]);
    assign tick        = en_q & (pcnt_q == prescale_q);
    // Upper bits are matched by the interconnect, byte offset bits carry no meaning.
    assign unused_addr = ^wb_if.addr;

    always_comb begin
        rd_mux = '0;
        unique case (reg_sel)
            REG_MTIME_LO: rd_mux = mtime_q[31:0];
            REG_MTIME_HI: rd_mux = mtime_q[63:32];
            REG_CMP_LO:   rd_mux = mtimecmp_q[31:0];
            REG_CMP_HI:   rd_mux = mtimecmp_q[63:32];
            REG_CTRL:     rd_mux = {31'd0, en_q};
            REG_PRESCALE: rd_mux = 32'(prescale_q);
            REG_RSV6,
            REG_RSV7:     rd_mux = '0;
        endcase
    end

    always_comb begin
        mtime_d    = mtime_q;
        mtimecmp_d = mtimecmp_q;
        en_d       = en_q;
        prescale_d = prescale_q;
        pcnt_d     = pcnt_q;

        if (en_q) begin
            if (tick) begin
                pcnt_d  = '0;
                mtime_d = mtime_q + 64'd1;
            end else begin
                pcnt_d  = pcnt_q + PRESCALE_W'(1);
            end
        end

        // A bus write to either mtime half overrides the tick for the whole 64 bits.
        if (wr_en) begin
            unique case (reg_sel)
                REG_MTIME_LO: mtime_d = {mtime_q[63:32],
                                         byte_merge(mtime_q[31:0], wb_if.wdata, wb_if.sel)};
                REG_MTIME_HI: mtime_d = {byte_merge(mtime_q[63:32], wb_if.wdata, wb_if.sel),
                                         mtime_q[31:0]};
                REG_CMP_LO:   mtimecmp_d[31:0]  = byte_merge(mtimecmp_q[31:0], wb_if.wdata, wb_if.sel);
                REG_CMP_HI:   mtimecmp_d[63:32] = byte_merge(mtimecmp_q[63:32], wb_if.wdata, wb_if.sel);
                REG_CTRL: begin
                    if (wb_if.sel[0]) begin
                        en_d = wb_if.wdata[0];
                    end
                end
                REG_PRESCALE: begin
                    prescale_d = byte_merge(32'(prescale_q), wb_if.wdata,
                                            wb_if.sel)[PRESCALE_W-1:0];
                    pcnt_d     = '0;
                end
                REG_RSV6,
                REG_RSV7: ;
            endcase
        end
    end

    always_comb begin
        ack_d   = accept;
        rdata_d = accept ? rd_mux : rdata_q;
        irq_d   = (mtime_q >= mtimecmp_q);
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            mtime_q    <= '0;
            mtimecmp_q <= '1;
            en_q       <= 1'b1;
            prescale_q <= '0;
            pcnt_q     <= '0;
            ack_q      <= 1'b0;
            rdata_q    <= '0;
            irq_q      <= 1'b0;
        end else begin
            mtime_q    <= mtime_d;
            mtimecmp_q <= mtimecmp_d;
            en_q       <= en_d;
            prescale_q <= prescale_d;
            pcnt_q     <= pcnt_d;
            ack_q      <= ack_d;
            rdata_q    <= rdata_d;
            irq_q      <= irq_d;
        end
    end

    assign wb_if.ack   = ack_q & wb_if.cyc;
    assign wb_if.rdata = rdata_q;
    assign wb_if.stall = 1'b0;
    assign wb_if.err   = 1'b0;
    assign wb_if.rty   = 1'b0;
    assign timer_irq_o = irq_q;

endmodule

// File: tb/tb_wb_timer.sv
// Directed bench for wb_timer: scoreboard of expected read data popped on each ack.
module tb_wb_timer;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    logic irq;

    int nchk = 0;
    int nerr = 0;

    typedef struct {
        string       tag;
        logic        chk;
        logic [31:0] lo;
        logic [31:0] hi;
    } exp_t;

    exp_t sbq[$];

    wishbone_if #(.AW(32)) wb ();

    wb_timer #(.AW(32), .PRESCALE_W(16)) dut (
        .clk_i       (clk),
        .rstn_i      (rstn),
        .wb_if       (wb),
        .timer_irq_o (irq)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Scoreboard consumer: every ack pops the oldest outstanding transaction.
    always @(negedge clk) begin
        if (wb.ack === 1'b1) begin
            nchk++;
            assert (sbq.size() != 0) else begin
                nerr++;
                $error("FAIL spurious_ack: observed ack expected none");
            end
            if (sbq.size() != 0) begin
                exp_t e;
                e = sbq.pop_front();
                if (e.chk) begin
                    nchk++;
                    assert ((wb.rdata >= e.lo && wb.rdata <= e.hi) === 1'b1) else begin
                        nerr++;
                        $error("FAIL %s: observed %h expected %h..%h", e.tag, wb.rdata, e.lo, e.hi);
                    end
                end
            end
        end
    end

    task automatic bus(input logic w, input logic [31:0] a, input logic [3:0] s,
                       input logic [31:0] d, input logic [31:0] lo, input logic [31:0] hi,
                       input string tag, output logic [31:0] v);
        exp_t e;
        e.tag = tag; e.chk = !w; e.lo = lo; e.hi = hi;
        sbq.push_back(e);
        wb.cyc = 1'b1; wb.stb = 1'b1; wb.we = w; wb.addr = a; wb.sel = s; wb.wdata = d;
        @(posedge clk);
        #1;
        wb.stb = 1'b0; wb.we = 1'b0;
        @(negedge clk);
        check({"ack_", tag}, {63'd0, wb.ack}, 64'd1);
        v = wb.rdata;
        #1;
        wb.cyc = 1'b0;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] dummy;
        bus(1'b1, a, s, d, '0, '0, "wr", dummy);
    endtask

    task automatic rd(input logic [31:0] a, input logic [31:0] lo, input logic [31:0] hi,
                      input string tag, output logic [31:0] v);
        bus(1'b0, a, 4'hF, '0, lo, hi, tag, v);
    endtask

    initial begin
        logic [31:0] v, r1, r2;
        logic [31:0] pa [4];
        logic [31:0] pe [4];
        pa[0] = 32'h08; pe[0] = 32'd1000;
        pa[1] = 32'h0C; pe[1] = 32'd0;
        pa[2] = 32'h10; pe[2] = 32'd1;
        pa[3] = 32'h14; pe[3] = 32'd0;

        wb.cyc = 1'b0; wb.stb = 1'b0; wb.we = 1'b0;
        wb.addr = '0; wb.sel = '0; wb.wdata = '0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_ack",   {63'd0, wb.ack},   64'd0);
        check("rst_rdata", {32'd0, wb.rdata}, 64'd0);
        check("rst_irq",   {63'd0, irq},      64'd0);
        check("rst_stall", {63'd0, wb.stall}, 64'd0);
        check("rst_err",   {63'd0, wb.err},   64'd0);
        check("rst_rty",   {63'd0, wb.rty},   64'd0);
        rstn = 1'b1;

        // Free run after reset
        repeat (10) @(posedge clk);
        #1;
        rd(32'h00, 32'd10, 32'd12, "freerun_lo", v);
        rd(32'h0C, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "cmp_hi_rst", v);

        // Byte lanes and unmapped space
        wr(32'h08, 32'hAABB_CCDD, 4'b0101);
        rd(32'h08, 32'hFFBB_FFDD, 32'hFFBB_FFDD, "byte_lanes", v);
        rd(32'h18, 32'd0, 32'd0, "unmapped_18", v);
        wr(32'h1C, 32'h1234_5678, 4'hF);
        rd(32'h1C, 32'd0, 32'd0, "unmapped_1c", v);

        // Prescaler
        wr(32'h14, 32'd3, 4'hF);
        wr(32'h00, 32'd0, 4'hF);
        wr(32'h04, 32'd0, 4'hF);
        repeat (40) @(posedge clk);
        #1;
        rd(32'h00, 32'd9, 32'd11, "prescale_lo", v);
        rd(32'h14, 32'd3, 32'd3, "prescale_rd", v);
        wr(32'h10, 32'd0, 4'hF);
        rd(32'h00, 32'd9, 32'd12, "frozen_a", r1);
        repeat (20) @(posedge clk);
        #1;
        rd(32'h00, 32'd9, 32'd12, "frozen_b", r2);
        check("frozen_eq", {32'd0, r2}, {32'd0, r1});
        rd(32'h10, 32'd0, 32'd0, "ctrl_off", v);

        // Interrupt
        wr(32'h14, 32'd0, 4'hF);
        wr(32'h0C, 32'd0, 4'hF);
        wr(32'h08, 32'd50, 4'hF);
        wr(32'h04, 32'd0, 4'hF);
        wr(32'h00, 32'd0, 4'hF);
        check("irq_idle", {63'd0, irq}, 64'd0);
        wr(32'h10, 32'd1, 4'hF);
        repeat (50) @(posedge clk);
        #1;
        check("irq_pre50", {63'd0, irq}, 64'd0);
        @(posedge clk);
        #1;
        check("irq_at50", {63'd0, irq}, 64'd1);
        wr(32'h08, 32'd1000, 4'hF);
        check("irq_hold", {63'd0, irq}, 64'd1);
        @(posedge clk);
        #1;
        check("irq_clear", {63'd0, irq}, 64'd0);

        // Wrap
        wr(32'h04, 32'hFFFF_FFFF, 4'hF);
        wr(32'h00, 32'hFFFF_FFFE, 4'hF);
        @(posedge clk);
        #1;
        check("irq_wrap_hi", {63'd0, irq}, 64'd1);
        @(posedge clk);
        #1;
        rd(32'h00, 32'd0, 32'd0, "wrap_lo", v);
        check("irq_wrap_clr", {63'd0, irq}, 64'd0);
        rd(32'h04, 32'd0, 32'd0, "wrap_hi", v);

        // Write vs tick collision
        wr(32'h00, 32'h1234_0000, 4'hF);
        rd(32'h00, 32'h1234_0000, 32'h1234_0000, "collide_lo", v);

        // Back-to-back strobes
        wb.cyc = 1'b1;
        for (int i = 0; i < 4; i++) begin
            exp_t e;
            e.tag = "pipe"; e.chk = 1'b1; e.lo = pe[i]; e.hi = pe[i];
            sbq.push_back(e);
            wb.stb = 1'b1; wb.we = 1'b0; wb.addr = pa[i]; wb.sel = 4'hF;
            @(posedge clk);
            #1;
            check("pipe_ack",   {63'd0, wb.ack},   64'd1);
            check("pipe_stall", {63'd0, wb.stall}, 64'd0);
        end
        wb.stb = 1'b0;
        @(posedge clk);
        #1;
        check("pipe_ack_end", {63'd0, wb.ack}, 64'd0);
        wb.cyc = 1'b0;

        // cyc dropped in the ack cycle: no ack, write still lands
        wb.cyc = 1'b1; wb.stb = 1'b1; wb.we = 1'b1; wb.addr = 32'h0C;
        wb.sel = 4'hF; wb.wdata = 32'd7;
        @(posedge clk);
        #1;
        wb.stb = 1'b0; wb.we = 1'b0; wb.cyc = 1'b0;
        @(negedge clk);
        check("cyc_drop_ack", {63'd0, wb.ack}, 64'd0);
        #1;
        rd(32'h0C, 32'd7, 32'd7, "cyc_drop_wr", v);

        // Async reset in the ack cycle
        wr(32'h0C, 32'd0, 4'hF);
        wr(32'h08, 32'd0, 4'hF);
        repeat (2) @(posedge clk);
        #1;
        check("irq_pre_rst", {63'd0, irq}, 64'd1);
        begin
            exp_t e;
            e.tag = "rst_drop"; e.chk = 1'b0; e.lo = '0; e.hi = '0;
            sbq.push_back(e);
        end
        wb.cyc = 1'b1; wb.stb = 1'b1; wb.we = 1'b0; wb.addr = 32'h10; wb.sel = 4'hF;
        @(posedge clk);
        #1;
        wb.stb = 1'b0;
        check("pre_rst_rdata", {32'd0, wb.rdata}, 64'd1);
        rstn = 1'b0;
        #1;
        check("arst_ack",   {63'd0, wb.ack},   64'd0);
        check("arst_rdata", {32'd0, wb.rdata}, 64'd0);
        check("arst_irq",   {63'd0, irq},      64'd0);
        sbq.delete();
        wb.cyc = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;
        @(posedge clk);
        #1;
        rd(32'h0C, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "cmp_hi_rst2", v);
        rd(32'h10, 32'd1, 32'd1, "ctrl_rst2", v);

        repeat (2) @(posedge clk);
        check("sb_empty", 64'(sbq.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
